aes_block_loader: RTL and testbench

- Upstream feeder for the 128-bit AES encrypt core.
- Accepts a byte stream over a valid/ready handshake and assembles a 16-byte secret key, then 16-byte plaintext blocks.
- Presents the key and plaintext as stable 128-bit words to the core and issues a one-cycle start pulse per block.
- Waits for the core's done indication before accepting the next block; the key is retained across blocks until reloaded.

---
 rtl/aes_block_loader.sv | 155 +++++++++++++++
 tb/tb_aes_block_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Byte-stream front end for a 128-bit AES encrypt core: gathers a 16-byte key,
// then 16-byte plaintext blocks, and hands each block to the core with a start pulse.
module aes_block_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_reload,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] secret_key,
    output logic [127:0] plain_text,
    output logic         start,
    input  logic         core_done,
    output logic         busy,
    output logic         key_valid,
    output logic         timeout_err
);

    typedef enum logic [1:0] {ST_KEY, ST_TEXT, ST_WAIT} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] shift_q, shift_d;
    logic [127:0] key_q, key_d;
    logic [127:0] text_q, text_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         key_valid_q, key_valid_d;
    logic         err_q, err_d;
    logic         pend_q, pend_d;
    logic [7:0]   tmo_q, tmo_d;

    logic         accept;
    logic         pend_now;
    logic [127:0] assembled;

    assign in_ready  = ~reset & (state_q != ST_WAIT);
    assign accept    = in_valid & in_ready;
    assign assembled = {shift_q[119:0], in_byte};
    assign pend_now  = pend_q | key_reload;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        key_d       = key_q;
        text_d      = text_q;
        start_d     = 1'b0;
        busy_d      = busy_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        pend_d      = pend_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            ST_KEY: begin
                if (key_reload) begin
                    cnt_d       = 4'd0;
                    shift_d     = '0;
                    key_valid_d = 1'b0;
                end else if (accept) begin
                    shift_d = assembled;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        key_d       = assembled;
                        key_valid_d = 1'b1;
                        state_d     = ST_TEXT;
                    end
                end
            end

            ST_TEXT: begin
                if (key_reload) begin
                    cnt_d       = 4'd0;
                    shift_d     = '0;
                    key_valid_d = 1'b0;
                    state_d     = ST_KEY;
                end else if (accept) begin
                    shift_d = assembled;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        text_d  = assembled;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        tmo_d   = 8'd0;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // core_done wins over a timeout landing on the same edge
                if (core_done || tmo_q == TMO_LAST) begin
                    if (!core_done) err_d = 1'b1;
                    busy_d  = 1'b0;
                    tmo_d   = 8'd0;
                    pend_d  = 1'b0;
                    if (pend_now) begin
                        key_valid_d = 1'b0;
                        state_d     = ST_KEY;
                    end else begin
                        state_d = ST_TEXT;
                    end
                end else begin
                    tmo_d  = tmo_q + 8'd1;
                    pend_d = pend_now;
                end
            end

            default: state_d = ST_KEY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            state_q     <= ST_KEY;
            cnt_q       <= 4'd0;
            shift_q     <= '0;
            key_q       <= '0;
            text_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            tmo_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            key_q       <= key_d;
            text_q      <= text_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            tmo_q       <= tmo_d;
        end
    end

    assign secret_key  = key_q;
    assign plain_text  = text_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign key_valid   = key_valid_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed scenarios plus random traffic,
// all compared cycle by cycle against a byte-queue reference model.
module tb_aes_block_loader;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_reload;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] secret_key;
    logic [127:0] plain_text;
    logic         start;
    logic         core_done;
    logic         busy;
    logic         key_valid;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    aes_block_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_reload (key_reload),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .secret_key (secret_key),
        .plain_text (plain_text),
        .start      (start),
        .core_done  (core_done),
        .busy       (busy),
        .key_valid  (key_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = collecting key, 1 = collecting text, 2 = core running
    int           m_phase;
    logic [7:0]   m_bytes[$];
    logic [127:0] m_key, m_text;
    logic         m_start, m_busy, m_kv, m_err, m_pend;
    int           m_wait;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack_bytes();
        logic [127:0] w = '0;
        for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = m_bytes[i];
        return w;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_bytes.delete();
        m_key = '0; m_text = '0;
        m_start = 0; m_busy = 0; m_kv = 0; m_err = 0; m_pend = 0;
        m_wait = 0;
    endtask

    task automatic model_leave_wait();
        m_busy = 0;
        if (m_pend) begin
            m_phase = 0;
            m_kv = 0;
        end else begin
            m_phase = 1;
        end
        m_pend = 0;
    endtask

    task automatic model_step(input logic rl, input logic v, input logic [7:0] b, input logic d);
        logic acc;
        acc = v && (m_phase != 2);
        m_start = 0;
        case (m_phase)
            0: begin
                if (rl) m_bytes.delete();
                else if (acc) begin
                    m_bytes.push_back(b);
                    if (m_bytes.size() == 16) begin
                        m_key = pack_bytes();
                        m_kv = 1;
                        m_bytes.delete();
                        m_phase = 1;
                    end
                end
            end
            1: begin
                if (rl) begin
                    m_bytes.delete();
                    m_kv = 0;
                    m_phase = 0;
                end else if (acc) begin
                    m_bytes.push_back(b);
                    if (m_bytes.size() == 16) begin
                        m_text = pack_bytes();
                        m_start = 1;
                        m_busy = 1;
                        m_bytes.delete();
                        m_wait = 0;
                        m_phase = 2;
                    end
                end
            end
            default: begin
                m_pend = m_pend | rl;
                m_wait++;
                if (d) model_leave_wait();
                else if (m_wait == TMO) begin
                    m_err = 1;
                    model_leave_wait();
                end
            end
        endcase
    endtask

    // One clock cycle: drive, check in_ready before the edge, update model, compare after the edge
    task automatic tick(input logic rst, input logic rl, input logic v, input logic [7:0] b, input logic d);
        reset = rst; key_reload = rl; in_valid = v; in_byte = b; core_done = d;
        #2;
        check("in_ready_pre", in_ready, !rst && m_phase != 2);
        @(posedge clk);
        if (rst) model_reset();
        else model_step(rl, v, b, d);
        #1;
        check("in_ready",    in_ready,    !rst && m_phase != 2);
        check("secret_key",  secret_key,  m_key);
        check("plain_text",  plain_text,  m_text);
        check("start",       start,       m_start);
        check("busy",        busy,        m_busy);
        check("key_valid",   key_valid,   m_kv);
        check("timeout_err", timeout_err, m_err);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input logic d);
        tick(1'b0, 1'b0, 1'b0, 8'($urandom), d);
    endtask

    task automatic send_seq(input logic [7:0] base, input bit gappy);
        for (int i = 0; i < 16; i++) begin
            if (gappy) idle(1'b0);
            send(base + 8'(i));
        end
    endtask

    localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] TEXT0 = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] TEXT1 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

    initial begin
        int done_pct;
        reset = 1; key_reload = 0; in_valid = 0; in_byte = 0; core_done = 0;
        model_reset();
        @(posedge clk); #1;

        // Reset and first block, back-to-back
        tick(1, 0, 0, 8'h00, 0);
        tick(1, 0, 1, 8'h55, 1);
        check("rst_key_zero", secret_key, 128'd0);
        send_seq(8'h00, 0);
        check("key0", secret_key, KEY0);
        check("key0_valid", key_valid, 1'b1);
        send_seq(8'h10, 0);
        check("text0", plain_text, TEXT0);
        check("start0", start, 1'b1);
        check("busy0", busy, 1'b1);
        check("ready0_wait", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) idle(0);
        check("start0_gone", start, 1'b0);
        idle(1);
        check("busy0_clear", busy, 1'b0);

        // Second block under the same key
        send_seq(8'ha0, 0);
        check("key_kept", secret_key, KEY0);
        check("text1", plain_text, TEXT1);
        check("start1", start, 1'b1);

        // Withhold core_done until the timeout fires
        for (int i = 0; i < TMO - 1; i++) idle(0);
        check("no_err_early", timeout_err, 1'b0);
        check("busy_before_tmo", busy, 1'b1);
        idle(0);
        check("tmo_err", timeout_err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_ready", in_ready, 1'b1);

        // Reload after 7 plaintext bytes; reload edge carries a byte that must be dropped
        for (int i = 0; i < 7; i++) send(8'($urandom));
        tick(0, 1, 1, 8'hee, 0);
        check("reload_kv", key_valid, 1'b0);
        for (int i = 0; i < 15; i++) send(8'h40 + 8'(i));
        check("kv_partial", key_valid, 1'b0);
        send(8'h4f);
        check("key_reloaded", secret_key, 128'h404142434445464748494a4b4c4d4e4f);
        send_seq(8'h60, 0);
        check("start_after_reload", start, 1'b1);
        check("text_after_reload", plain_text, 128'h606162636465666768696a6b6c6d6e6f);
        check("err_sticky", timeout_err, 1'b1);

        // Reload during WAIT takes effect only after done
        idle(0);
        tick(0, 1, 0, 8'h00, 0);
        idle(0);
        check("kv_in_wait", key_valid, 1'b1);
        idle(1);
        check("kv_after_done", key_valid, 1'b0);
        send_seq(8'h80, 0);
        check("key_after_wait_reload", secret_key, 128'h808182838485868788898a8b8c8d8e8f);
        check("text_untouched", plain_text, 128'h606162636465666768696a6b6c6d6e6f);

        // Gappy in_valid gives the same words as back-to-back
        tick(1, 0, 0, 8'h00, 0);
        send_seq(8'h00, 1);
        check("key_gappy", secret_key, KEY0);
        send_seq(8'h10, 1);
        check("text_gappy", plain_text, TEXT0);
        idle(1);

        // Reset in the middle of a text block
        for (int i = 0; i < 5; i++) send(8'($urandom));
        tick(1, 0, 1, 8'h33, 0);
        check("midrst_key", secret_key, 128'd0);
        check("midrst_text", plain_text, 128'd0);
        check("midrst_kv", key_valid, 1'b0);
        tick(0, 0, 0, 8'h00, 0);

        // Random traffic
        done_pct = 10;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: done_pct = 0;
                    1: done_pct = 8;
                    default: done_pct = 40;
                endcase
            end
            tick(($urandom_range(0, 999) < 2),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 8'($urandom),
                 ($urandom_range(0, 99) < done_pct));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
